// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the Maxnet channel-scan datapath.
//   state_e       : scan controller states
//   clog2()       : ceiling log2 usable in parameter expressions
//   DEFAULT_WIDTH : default channel value width
//   DEFAULT_N     : default channel count
package maxnet_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_N     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsb_onehot_pick.sv
// Picks the lowest set bit of vec_i strictly above the one-hot floor_i.
// A zero floor_i means "no floor": the lowest set bit of vec_i is returned.
//   vec_i   [N] : candidate bit vector
//   floor_i [N] : one-hot lower bound (exclusive), or zero
//   pick_o  [N] : one-hot result, zero when nothing qualifies
//   none_o      : no qualifying bit
module lsb_onehot_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] vec_i,
    input  logic [N-1:0] floor_i,
    output logic [N-1:0] pick_o,
    output logic         none_o
);

    logic [N-1:0] above;
    logic [N-1:0] cand;

    always_comb begin
        // Bits strictly above the floor; floor-1 fills everything below it.
        above  = (floor_i == '0) ? '1 : ~(floor_i | (floor_i - N'(1)));
        cand   = vec_i & above;
        // Two's-complement trick isolates the lowest set bit.
        pick_o = cand & (~cand + N'(1));
        none_o = (cand == '0);
    end

endmodule

// File: rtl/onehot_scan_mux.sv
// Snapshots N channel values plus an active mask, then streams the active
// channels lowest index first over valid/ready, ending with a done pulse.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a scan (IDLE only)
//   data_in[N*WIDTH]  : flat channel vector, channel i at [i*WIDTH +: WIDTH]
//   active_mask[N]    : channels taking part in the scan
//   out_ready         : downstream accepts the current beat
//   y, y_sel, y_idx   : selected value, one-hot select, binary index
//   y_valid, y_last   : beat valid, final active channel
//   busy, done        : scan in progress, one-cycle end-of-scan pulse
//   beat_count        : beats accepted in the current or last scan
module onehot_scan_mux
    import maxnet_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned IDXW  = (clog2(N) < 1) ? 1 : clog2(N),
    parameter int unsigned CNTW  = clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [N-1:0]       active_mask,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic [N-1:0]       y_sel,
    output logic [IDXW-1:0]    y_idx,
    output logic               y_valid,
    output logic               y_last,
    output logic               busy,
    output logic               done,
    output logic [CNTW-1:0]    beat_count
);

    state_e             state_q;
    logic [N*WIDTH-1:0] data_q;
    logic [N-1:0]       mask_q;

    logic [N-1:0]       pick_vec;
    logic [N-1:0]       pick_floor;
    logic [N-1:0]       nxt_ptr;
    logic               pick_none;
    logic [N*WIDTH-1:0] src_data;
    logic [WIDTH-1:0]   nxt_y;
    logic [IDXW-1:0]    nxt_idx;
    logic               nxt_last;

    // y_sel doubles as the scan pointer: it is one-hot in SCAN, zero otherwise.
    always_comb begin
        pick_vec   = (state_q == IDLE) ? active_mask : mask_q;
        pick_floor = (state_q == IDLE) ? '0 : y_sel;
        src_data   = (state_q == IDLE) ? data_in : data_q;
        nxt_y      = '0;
        nxt_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (nxt_ptr[i]) begin
                nxt_y   = src_data[i*WIDTH +: WIDTH];
                nxt_idx = IDXW'(i);
            end
        end
        // Next beat is last when no mask bit sits above the next pointer.
        nxt_last = ~|(pick_vec & ~(nxt_ptr | (nxt_ptr - N'(1))));
    end

    lsb_onehot_pick #(
        .N (N)
    ) u_pick (
        .vec_i   (pick_vec),
        .floor_i (pick_floor),
        .pick_o  (nxt_ptr),
        .none_o  (pick_none)
    );

    // Scan controller with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            y          <= '0;
            y_sel      <= '0;
            y_idx      <= '0;
            y_valid    <= 1'b0;
            y_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beat_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q     <= data_in;
                        mask_q     <= active_mask;
                        beat_count <= '0;
                        if (pick_none) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                            busy    <= 1'b1;
                            y_valid <= 1'b1;
                            y_sel   <= nxt_ptr;
                            y_idx   <= nxt_idx;
                            y       <= nxt_y;
                            y_last  <= nxt_last;
                        end
                    end
                end
                SCAN: begin
                    if (y_valid && out_ready) begin
                        beat_count <= beat_count + CNTW'(1);
                        if (y_last) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            y_valid <= 1'b0;
                            y_sel   <= '0;
                            y_idx   <= '0;
                            y       <= '0;
                            y_last  <= 1'b0;
                        end else begin
                            y_sel  <= nxt_ptr;
                            y_idx  <= nxt_idx;
                            y      <= nxt_y;
                            y_last <= nxt_last;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/onehot_scan_mux.md
Name: onehot_scan_mux

Overview:
- Parametrised successor to the Maxnet one-hot 4:1 select mux. Snapshots N neuron values and an active-channel mask.
- Streams only the active channels, lowest index first, one per accepted beat, over a valid/ready interface.
- Feeds the serial accumulator / inhibition stage of the Maxnet datapath, replacing fixed one-hot selection and its undefined outputs.

Parameters:
- WIDTH, 32, bit width of each channel value.
- N, 4, channel count (N >= 2).
- IDXW, clog2(N) (minimum 1), width of the binary index output.
- CNTW, clog2(N+1), width of the beat counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- data_in  in  N*WIDTH  flat channel vector; channel i is at bits [i*WIDTH +: WIDTH].
- active_mask  in  N  bit i = 1 means channel i takes part in the scan.
- out_ready  in  1  downstream accepts the current beat.
- y  out  WIDTH  selected channel value.
- y_sel  out  N  one-hot code of the selected channel.
- y_idx  out  IDXW  binary index of the selected channel.
- y_valid  out  1  beat valid.
- y_last  out  1  current beat is the final active channel.
- busy  out  1  scan in progress (SCAN state).
- done  out  1  one-cycle pulse at the end of a scan.
- beat_count  out  CNTW  beats accepted in the current or last scan.

Behaviour:
- Reset, synchronous, active-high: state = IDLE; y, y_sel, y_idx, y_valid, y_last, busy, done, beat_count all 0; snapshot registers cleared. Reset overrides every other input, including mid-scan; the pending scan is dropped without a done pulse.
- Outputs are never X. Whenever y_valid = 0, y, y_sel, y_idx and y_last are all 0.
- State IDLE:
  - start = 1 captures data_reg <= data_in and mask_reg <= active_mask, and clears beat_count.
  - If active_mask != 0: ptr <= lowest set bit of active_mask, go to SCAN.
  - If active_mask == 0: go to DONE (empty scan, no beats).
- State SCAN:
  - Combinational outputs: y_valid = 1, busy = 1, y_sel = ptr (one-hot), y = data_reg selected by ptr, y_idx = binary of ptr.
  - y_last = 1 when mask_reg has no set bit above ptr.
  - Outputs are held stable while out_ready = 0; this is standard valid/ready, and y_valid does not drop without acceptance.
  - On a handshake (y_valid & out_ready): beat_count increments.
  - If y_last: go to DONE.
  - Otherwise ptr <= lowest set bit of mask_reg strictly above ptr. The next beat is presented in the following cycle with no bubble.
  - start is ignored in SCAN. Changes on data_in and active_mask have no effect after capture.
- State DONE: done = 1 for exactly one cycle, then return to IDLE. start in DONE is ignored.
- Latency:
  - start at cycle t gives the first valid beat at t+1.
  - With out_ready held at 1, a scan of k active channels gives beats t+1..t+k and done at t+k+1.
  - An empty mask gives done at t+1.
- beat_count holds its value through DONE and IDLE until the next accepted start.
- ptr is always one-hot or zero, never multi-hot.

Decomposition:
- Shared package, maxnet_pkg:
  - typedef for the state enum {IDLE, SCAN, DONE}.
  - clog2 helper function.
  - default constants for WIDTH and N.
- One sub-module, lsb_onehot_pick (parameter N): combinational.
  - Inputs: vec[N] and a one-hot floor[N].
  - Outputs: the lowest set bit of vec strictly above floor, as one-hot, plus a none flag.
  - When floor = 0 it returns the lowest set bit of vec.
  - It is used both for the first pick and for each advance.

Test Plan:
- N=4, WIDTH=32, mask=4'b1111, data={D3=40,D2=30,D1=20,D0=10}, out_ready held 1, start at t -> y = 10,20,30,40 at t+1..t+4; y_sel = 0001,0010,0100,1000; y_last only at t+4; done at t+5; beat_count = 4.
- mask=4'b1010, same data -> exactly two beats, y = 20 (idx 1) then 40 (idx 3, y_last = 1); channels 0 and 2 never appear.
- mask=4'b0101 with out_ready low for 3 cycles during beat 1 -> y = 10 held with y_valid = 1 for those cycles; no advance until out_ready = 1; then y = 30 with y_last = 1.
- mask=0, start -> y_valid stays 0, done pulses at t+1, beat_count = 0.
- Mid-scan, data_in and mask change, start re-pulsed, then rst asserted on the second beat -> the changes are ignored before rst; next cycle state is IDLE with all outputs 0 and no done pulse; a fresh start works normally afterwards.
- N=8, mask=8'b1000_0000 -> a single beat with y_idx = 7 and y_last = 1, then done.
